// File: rtl/commit_trace_pkg.sv
// Shared record type and field widths for the commit-trace serializer.
// Vector payload fields exist only when COMMIT_TRACE_VEC_EN is defined.
package commit_trace_pkg;
    localparam int PC_W      = 40;
    localparam int XLEN      = 64;
    localparam int LREG_W    = 5;
    localparam int INST_W    = 32;
    localparam int RTYPE_W   = 3;
    localparam int HART_W    = 8;
    // Records carry the widest supported sequence number; the top keeps the low SEQ_W bits.
    localparam int SEQ_MAX_W = 64;
`ifdef COMMIT_TRACE_VEC_EN
    localparam int VLEN_MAX  = 256;
`endif

    typedef struct packed {
        logic [HART_W-1:0]     hartid;
        logic [LREG_W-1:0]     ldst;
        logic [RTYPE_W-1:0]    dst_rtype;
        logic [PC_W-1:0]       pc;
        logic [INST_W-1:0]     inst;
        logic [XLEN-1:0]       wdata;
        logic [SEQ_MAX_W-1:0]  seq;
`ifdef COMMIT_TRACE_VEC_EN
        logic [VLEN_MAX*8-1:0] vec_wdata;
        logic [7:0]            vec_wmask;
`endif
    } commit_rec_t;
endpackage

// File: rtl/commit_trace_fifo.sv
// Circular buffer of commit records: up to RETIRE_W writes and one read per cycle.
// The head is read combinationally so a record is visible the cycle after it is written.
module commit_trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int RETIRE_W = 3,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1,
    localparam int NW      = $clog2(RETIRE_W + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [NW-1:0] wr_n,
    input  commit_rec_t   wr_data [RETIRE_W],
    input  logic          rd_en,
    output commit_rec_t   rd_data,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);
    commit_rec_t mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [RETIRE_W-1:0][AW-1:0] wr_idx;
    logic unused_ptr_msb;

    genvar gi;
    generate
        for (gi = 0; gi < RETIRE_W; gi++) begin : g_wr_idx
            assign wr_idx[gi] = AW'(wr_ptr + CW'(gi));
        end
    endgenerate

    assign count_next     = count + CW'(wr_n) - CW'(rd_en);
    assign rd_data        = mem[rd_ptr[AW-1:0]];
    assign unused_ptr_msb = wr_ptr[AW] ^ rd_ptr[AW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + CW'(wr_n);
            rd_ptr <= rd_ptr + CW'(rd_en);
            count  <= count_next;
        end
    end

    // Storage is not reset; the head is qualified by count at the top.
    always_ff @(posedge clock) begin
        for (int k = 0; k < RETIRE_W; k++) begin
            if (k < int'(wr_n)) begin
                mem[wr_idx[k]] <= wr_data[k];
            end
        end
    end
endmodule

// File: rtl/commit_trace_serializer.sv
// Compacts retiring uops into hartid/seq-stamped commit records and streams them out one per cycle.
// Defining COMMIT_TRACE_VEC_EN adds the per-record vector writeback payload.
module commit_trace_serializer
    import commit_trace_pkg::*;
#(
    parameter int RETIRE_W = 3,
    parameter int DEPTH    = 16,
    parameter int SEQ_W    = 32,
    parameter int VLEN     = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [HART_W-1:0]            hartid,
    input  logic [RETIRE_W-1:0]          commit_valid,
    output logic                         commit_ready,
    input  logic [LREG_W*RETIRE_W-1:0]   commit_ldst,
    input  logic [RTYPE_W*RETIRE_W-1:0]  commit_dst_rtype,
    input  logic [PC_W*RETIRE_W-1:0]     commit_pc,
    input  logic [INST_W*RETIRE_W-1:0]   commit_inst,
    input  logic [XLEN*RETIRE_W-1:0]     commit_wdata,
`ifdef COMMIT_TRACE_VEC_EN
    input  logic [VLEN*8*RETIRE_W-1:0]   commit_vec_wdata,
    input  logic [8*RETIRE_W-1:0]        commit_vec_wmask,
    output logic [VLEN*8-1:0]            out_vec_wdata,
    output logic [7:0]                   out_vec_wmask,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [HART_W-1:0]            out_hartid,
    output logic [LREG_W-1:0]            out_ldst,
    output logic [RTYPE_W-1:0]           out_dst_rtype,
    output logic [PC_W-1:0]              out_pc,
    output logic [INST_W-1:0]            out_inst,
    output logic [XLEN-1:0]              out_wdata,
    output logic [SEQ_W-1:0]             out_seq,
    output logic                         overflow,
    output logic [15:0]                  drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(RETIRE_W + 1);

    generate
        if (DEPTH < 2 * RETIRE_W || (DEPTH & (DEPTH - 1)) != 0 || SEQ_W > SEQ_MAX_W || VLEN < 1
`ifdef COMMIT_TRACE_VEC_EN
            || VLEN > VLEN_MAX
`endif
        ) begin : g_bad_cfg
            $error("commit_trace_serializer: unsupported parameter combination");
        end
    endgenerate

    commit_rec_t   comp_rec [RETIRE_W];
    commit_rec_t   head;
    logic [NW-1:0] n_valid;
    logic [NW-1:0] wr_n;
    logic          push;
    logic          drop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [SEQ_W-1:0] seq_q;
    logic          ready_q;
    logic          overflow_q;
    logic [15:0]   drop_q;
    logic [16:0]   drop_sum;
    logic          unused_head;

    assign n_valid  = NW'($countones(commit_valid));
    assign push     = ready_q && (n_valid != '0);
    assign drop     = !ready_q && (n_valid != '0);
    assign wr_n     = push ? n_valid : '0;
    assign drop_sum = {1'b0, drop_q} + 17'(n_valid);

    // Valid lanes are packed into slots 0..n-1 in lane order; slot k gets seq_q + k.
    always_comb begin
        commit_rec_t rec;
        int slot;
        comp_rec = '{default: '0};
        slot     = 0;
        for (int i = 0; i < RETIRE_W; i++) begin
            rec           = '0;
            rec.hartid    = hartid;
            rec.ldst      = commit_ldst[i*LREG_W +: LREG_W];
            rec.dst_rtype = commit_dst_rtype[i*RTYPE_W +: RTYPE_W];
            rec.pc        = commit_pc[i*PC_W +: PC_W];
            rec.inst      = commit_inst[i*INST_W +: INST_W];
            rec.wdata     = commit_wdata[i*XLEN +: XLEN];
            rec.seq       = SEQ_MAX_W'(seq_q + SEQ_W'(slot));
`ifdef COMMIT_TRACE_VEC_EN
            rec.vec_wdata = (VLEN_MAX*8)'(commit_vec_wdata[i*VLEN*8 +: VLEN*8]);
            rec.vec_wmask = commit_vec_wmask[i*8 +: 8];
`endif
            if (commit_valid[i]) begin
                comp_rec[slot] = rec;
                slot           = slot + 1;
            end
        end
    end

    commit_trace_fifo #(
        .DEPTH    (DEPTH),
        .RETIRE_W (RETIRE_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .wr_n       (wr_n),
        .wr_data    (comp_rec),
        .rd_en      (out_valid && out_ready),
        .rd_data    (head),
        .count      (count),
        .count_next (count_next)
    );

    // Readiness looks only at post-update occupancy, so out_ready has no path to commit_ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ready_q <= (CW'(DEPTH) - count_next) >= CW'(RETIRE_W);
            if (push) begin
                seq_q <= seq_q + SEQ_W'(n_valid);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                drop_q     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    assign commit_ready  = ready_q;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_q;
    assign out_valid     = (count != '0);
    assign out_hartid    = out_valid ? head.hartid    : '0;
    assign out_ldst      = out_valid ? head.ldst      : '0;
    assign out_dst_rtype = out_valid ? head.dst_rtype : '0;
    assign out_pc        = out_valid ? head.pc        : '0;
    assign out_inst      = out_valid ? head.inst      : '0;
    assign out_wdata     = out_valid ? head.wdata     : '0;
    assign out_seq       = out_valid ? head.seq[SEQ_W-1:0] : '0;
`ifdef COMMIT_TRACE_VEC_EN
    assign out_vec_wdata = out_valid ? head.vec_wdata[VLEN*8-1:0] : '0;
    assign out_vec_wmask = out_valid ? head.vec_wmask : '0;
`endif
    assign unused_head   = ^head;
endmodule

// File: tb/tb_commit_trace_serializer.sv
// Scoreboard bench for commit_trace_serializer; a second instance with SEQ_W=4 checks sequence wrap.
module tb_commit_trace_serializer;
    localparam int RW = 3;

    typedef struct {
        logic [39:0] pc;
        logic [4:0]  ldst;
        logic [2:0]  rt;
        logic [31:0] inst;
        logic [63:0] wd;
        logic [31:0] seq;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0]       hartid = 8'h2A;
    logic [RW-1:0]    commit_valid = '0;
    logic [5*RW-1:0]  commit_ldst = '0;
    logic [3*RW-1:0]  commit_dst_rtype = '0;
    logic [40*RW-1:0] commit_pc = '0;
    logic [32*RW-1:0] commit_inst = '0;
    logic [64*RW-1:0] commit_wdata = '0;
    logic             out_ready = 1'b1;

    logic        commit_ready, out_valid, overflow;
    logic [7:0]  out_hartid;
    logic [4:0]  out_ldst;
    logic [2:0]  out_dst_rtype;
    logic [39:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] out_wdata;
    logic [31:0] out_seq;
    logic [15:0] drop_cnt;

    logic        ready4, valid4, ovf4;
    logic [7:0]  hart4;
    logic [4:0]  ldst4;
    logic [2:0]  rt4;
    logic [39:0] pc4;
    logic [31:0] inst4;
    logic [63:0] wd4;
    logic [3:0]  seq4;
    logic [15:0] drop4;

`ifdef COMMIT_TRACE_VEC_EN
    logic [256*8*RW-1:0] vec_in = '0;
    logic [8*RW-1:0]     vmask_in = '0;
    logic [256*8-1:0]    vec_out, vec_out4;
    logic [7:0]          vmask_out, vmask_out4;
`endif

    commit_trace_serializer dut (
        .clock(clock), .reset(reset), .hartid(hartid),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_ldst(commit_ldst), .commit_dst_rtype(commit_dst_rtype),
        .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_wdata(commit_wdata),
`ifdef COMMIT_TRACE_VEC_EN
        .commit_vec_wdata(vec_in), .commit_vec_wmask(vmask_in),
        .out_vec_wdata(vec_out), .out_vec_wmask(vmask_out),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hartid(out_hartid), .out_ldst(out_ldst), .out_dst_rtype(out_dst_rtype),
        .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata), .out_seq(out_seq),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    commit_trace_serializer #(.SEQ_W(4)) dut4 (
        .clock(clock), .reset(reset), .hartid(hartid),
        .commit_valid(commit_valid), .commit_ready(ready4),
        .commit_ldst(commit_ldst), .commit_dst_rtype(commit_dst_rtype),
        .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_wdata(commit_wdata),
`ifdef COMMIT_TRACE_VEC_EN
        .commit_vec_wdata(vec_in), .commit_vec_wmask(vmask_in),
        .out_vec_wdata(vec_out4), .out_vec_wmask(vmask_out4),
`endif
        .out_valid(valid4), .out_ready(out_ready),
        .out_hartid(hart4), .out_ldst(ldst4), .out_dst_rtype(rt4),
        .out_pc(pc4), .out_inst(inst4), .out_wdata(wd4), .out_seq(seq4),
        .overflow(ovf4), .drop_cnt(drop4)
    );

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned seq_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Presents one bundle for one cycle; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input logic [2:0] v, input logic [39:0] base);
        logic [39:0] p;
        exp_t e;
        commit_valid = v;
        for (int i = 0; i < RW; i++) begin
            p = base + 40'(4 * i);
            commit_pc[i*40 +: 40]       = p;
            commit_ldst[i*5 +: 5]       = p[6:2];
            commit_dst_rtype[i*3 +: 3]  = 3'(i + 1);
            commit_inst[i*32 +: 32]     = p[31:0] ^ 32'hDEAD_0000;
            commit_wdata[i*64 +: 64]    = {p[31:0], ~p[31:0]};
        end
        @(negedge clock);
        if (v != '0 && commit_ready) begin
            for (int i = 0; i < RW; i++) begin
                if (v[i]) begin
                    p      = base + 40'(4 * i);
                    e.pc   = p;
                    e.ldst = p[6:2];
                    e.rt   = 3'(i + 1);
                    e.inst = p[31:0] ^ 32'hDEAD_0000;
                    e.wd   = {p[31:0], ~p[31:0]};
                    e.seq  = seq_m;
                    seq_m++;
                    q.push_back(e);
                end
            end
        end
        @(posedge clock);
        #1;
        commit_valid = '0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && k < 300) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(posedge clock);
        #1;
        chk("idle_out_valid", 64'(out_valid), 64'd0);
    endtask

    // Monitor: compares every popped record against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %0h expected no record", out_pc);
                end else begin
                    e = q.pop_front();
                    $display("pop pc=%h seq=%0d seq4=%0d", out_pc, out_seq, seq4);
                    chk("rec_pc", 64'(out_pc), 64'(e.pc));
                    chk("rec_seq", 64'(out_seq), 64'(e.seq));
                    chk("rec_hartid", 64'(out_hartid), 64'h2A);
                    chk("rec_ldst", 64'(out_ldst), 64'(e.ldst));
                    chk("rec_rtype", 64'(out_dst_rtype), 64'(e.rt));
                    chk("rec_inst", 64'(out_inst), 64'(e.inst));
                    chk("rec_wdata", out_wdata, e.wd);
                    chk("seq4_wrap", 64'({valid4, pc4, seq4}), 64'({1'b1, e.pc, e.seq[3:0]}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_low, saw_rise;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_commit_ready", 64'(commit_ready), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_out_pc_gated", 64'(out_pc), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_before_edge", 64'(commit_ready), 64'd0);
        @(posedge clock);
        #1;
        chk("ready_after_edge", 64'(commit_ready), 64'd1);

        // Full bundle: record visible the cycle after the push edge.
        drive(3'b111, 40'h100);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_pc", 64'(out_pc), 64'h100);
        drain();

        // Sparse bundle: lane1 must be skipped.
        drive(3'b101, 40'h200);
        drain();

        // Fill with the consumer stalled, then overflow.
        out_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            drive(3'b111, 40'h300 + 40'(b * 16));
            if (b == 3) chk("ready_at_12", 64'(commit_ready), 64'd1);
        end
        chk("ready_at_15", 64'(commit_ready), 64'd0);
        chk("stall_head_pc", 64'(out_pc), 64'h300);
        drive(3'b011, 40'h400);
        chk("overflow_set", 64'(overflow), 64'd1);
        chk("drop_cnt_2", 64'(drop_cnt), 64'd2);
        drain();

        // Sustained 3-wide producer honouring commit_ready.
        saw_low  = 1'b0;
        saw_rise = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!commit_ready) saw_low = 1'b1;
            else if (saw_low) saw_rise = 1'b1;
            drive(commit_ready ? 3'b111 : 3'b000, 40'h1000 + 40'(i * 16));
        end
        chk("ready_toggled", 64'({saw_low, saw_rise}), 64'b11);
        drain();
        chk("drop_cnt_held", 64'(drop_cnt), 64'd2);

        // Reset with 7 records buffered.
        out_ready = 1'b0;
        drive(3'b111, 40'h2000);
        drive(3'b111, 40'h2010);
        drive(3'b001, 40'h2020);
        chk("seven_buffered_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_pc", 64'(out_pc), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        q.delete();
        seq_m = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        drive(3'b111, 40'h3000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_serializer.md
# commit_trace_serializer

Core-side producer of the commit-trace stream. Each cycle it accepts up to RETIRE_W retiring uops from the ROB commit port. It compacts the valid lanes in lane order, stamps each record with hartid and a sequence number, and buffers the records in a FIFO. Records leave one per cycle over a valid/ready handshake toward the harness, which consumes them as commit records.

## Interface
Parameters:
- RETIRE_W, default 3: commit lanes.
- DEPTH, default 16: FIFO entries; power of 2, at least 2*RETIRE_W.
- SEQ_W, default 32: sequence-number width.
- VLEN, default 256: vector register length; used only under the configuration macro.

Ports (lane i occupies bits [i*W +: W] of packed buses):
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- hartid  in  8  stamped into every record.
- commit_valid  in  RETIRE_W  per-lane retire valid.
- commit_ready  out  1  registered; bundle accepted when 1.
- commit_ldst  in  5*RETIRE_W  logical destination.
- commit_dst_rtype  in  3*RETIRE_W  destination register type.
- commit_pc  in  40*RETIRE_W  uop PC.
- commit_inst  in  32*RETIRE_W  instruction bits.
- commit_wdata  in  64*RETIRE_W  scalar writeback data.
- out_valid  out  1  head record valid.
- out_ready  in  1  consumer accepts the head record.
- out_hartid / out_ldst / out_dst_rtype / out_pc / out_inst / out_wdata  out  8/5/3/40/32/64  head record fields.
- out_seq  out  SEQ_W  record sequence number.
- overflow  out  1  sticky; set when valid lanes are presented while commit_ready=0.
- drop_cnt  out  16  saturating count of dropped uops.

## Operation
- Push condition: commit_ready=1 and popcount(commit_valid) = n > 0.
  - The n valid lanes are written to FIFO slots wr_ptr … wr_ptr+n-1 in ascending lane order.
  - Invalid lanes are skipped, so valid={1,0,1} writes lane0 then lane2.
- Sequence numbers: record k of a bundle gets out_seq = seq_q + k. seq_q advances by n and wraps mod 2^SEQ_W.
- Pop condition: out_valid && out_ready. Pop advances rd_ptr by 1.
- Occupancy: count_next = count + pushed − popped. Simultaneous push and pop is legal in every state.
- Readiness: commit_ready_q <= (DEPTH − count_next) >= RETIRE_W. Readiness is conservative, independent of commit_valid, and has no combinational path from out_ready.
- Drops: commit_valid≠0 while commit_ready=0 drops the whole bundle.
  - overflow is set and stays set until reset.
  - drop_cnt += popcount, saturating at 0xFFFF.
  - seq_q does not advance.
- Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are derived from count.

## Timing
- Reset values:
  - out_valid=0, commit_ready=0, overflow=0, drop_cnt=0, seq_q=0, count=0, both pointers 0.
  - All out_* data fields read 0 while out_valid=0; they are gated.
- commit_ready rises on the first clock edge after reset deasserts.
- Latency: a record pushed at edge N is presented as out_valid from cycle N+1. There is no same-cycle bypass.
- Throughput:
  - Output: 1 record/cycle.
  - Input: up to RETIRE_W records/cycle while space allows.
- Handshake rules:
  - Head fields are stable while out_valid && !out_ready.
  - out_valid never drops without a pop.
- Reset asserted mid-stream discards all buffered records immediately (asynchronous) and restarts seq at 0.

## Configuration
- COMMIT_TRACE_VEC_EN defined:
  - Adds commit_vec_wdata (in, VLEN*8*RETIRE_W) and commit_vec_wmask (in, 8*RETIRE_W).
  - Adds out_vec_wdata (out, VLEN*8) and out_vec_wmask (out, 8), carried per record under the same rules.
- Undefined: these ports and their storage do not exist; all other behaviour is identical.

## Structure
- Package commit_trace_pkg holds:
  - the commit_rec_t packed struct (hartid, ldst, dst_rtype, pc, inst, wdata, seq, plus vec fields under the macro);
  - the width constants PC_W=40, XLEN=64, LREG_W=5.
- Sub-module commit_trace_fifo: multi-write (up to RETIRE_W), single-read circular buffer of commit_rec_t carrying count and pointers.
- The top level contains lane compaction, seq, ready, and drop logic.

## Test plan
- After reset, commit_valid=3'b111, pc=0x100/0x104/0x108 → three outputs on consecutive cycles starting 1 cycle later, seq 0,1,2, in that PC order.
- commit_valid=3'b101 → two records: lane0 then lane2, seq consecutive; lane1 never appears.
- Hold out_ready=0 and push bundles of 3:
  - With DEPTH=16, after the 5th bundle (15 records) commit_ready=0.
  - A 6th bundle of valid=3'b011 is dropped: overflow=1, drop_cnt=2, no seq gap afterwards.
- Continuous 3-wide pushes with out_ready=1 for 100 cycles → commit_ready toggles as the FIFO fills; no record lost or reordered; out_seq is strictly +1 per pop.
- SEQ_W=4, push 20 records → out_seq wraps 15→0 with no loss.
- Assert reset with 7 records buffered → out_valid=0 immediately; after release, the next record has out_seq=0.
